// File: rtl/ps2_key_ctrl_if.sv
// Byte-strobe input and key/move output bundle
// for the PS/2 scan-code sequencer.
interface ps2_key_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       key_left;
  logic       key_right;
  logic       key_fire;
  logic       paused;
  logic       move_left;
  logic       move_right;
  logic       fire_pulse;
  logic       err;

  modport master (
    output rx_valid, rx_data,
    input  key_left, key_right, key_fire, paused,
    input  move_left, move_right, fire_pulse, err
  );

  modport slave (
    input  rx_valid, rx_data,
    output key_left, key_right, key_fire, paused,
    output move_left, move_right, fire_pulse, err
  );
endinterface

// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code sequencer: prefix FSM, held keys,
// rate-limited move pulses, fire/pause edges, timeout.
module ps2_key_ctrl #(
  parameter logic [19:0] MOVE_DIV   = 20'd250000,
  parameter logic [19:0] TIMEOUT    = 20'd500000,
  parameter logic [7:0]  LEFT_CODE  = 8'h6B,
  parameter logic [7:0]  RIGHT_CODE = 8'h74,
  parameter logic [7:0]  FIRE_CODE  = 8'h29,
  parameter logic [7:0]  PAUSE_CODE = 8'h4D
) (
  input logic            clk,
  input logic            rst,
  ps2_key_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_make;
  logic        w_brk;
  logic        w_err;
  logic        w_tout;
  logic        w_ign;
  logic        w_e0;
  logic        w_f0;
  logic [19:0] r_tcnt;
  logic [19:0] r_cnt;
  logic [19:0] w_cur;
  logic        r_left;
  logic        r_right;
  logic        r_fire;
  logic        r_pause;
  logic        r_paused;
  logic        r_fire_p;
  logic        r_err;
  logic        r_mv_l;
  logic        r_mv_r;
  logic        r_dir_l;
  logic        r_dir_r;
  logic        w_l;
  logic        w_r;
  logic        w_fresh;

  assign w_e0  = (bus.rx_data == 8'hE0);
  assign w_f0  = (bus.rx_data == 8'hF0);
  assign w_ign = bus.rx_data inside
    {8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF};

  // Fires on the edge where tcnt would reach TIMEOUT-1
  assign w_tout = (r_state != IDLE) && !bus.rx_valid
    && (r_tcnt == TIMEOUT - 20'd2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_make      = 1'b0;
    w_brk       = 1'b0;
    w_err       = 1'b0;
    if (bus.rx_valid) begin
      unique case (r_state)
        IDLE: begin
          if (w_e0)        w_state_nxt = EXT;
          else if (w_f0)   w_state_nxt = BRK;
          else if (!w_ign) w_make = 1'b1;
        end
        EXT: begin
          if (w_f0) begin
            w_state_nxt = EXT_BRK;
          end else begin
            w_state_nxt = IDLE;
            w_err       = w_e0;
            w_make      = !w_e0;
          end
        end
        BRK, EXT_BRK: begin
          w_state_nxt = IDLE;
          w_err       = w_e0 | w_f0;
          w_brk       = !(w_e0 | w_f0);
        end
        default: w_state_nxt = IDLE;
      endcase
    end else if (w_tout) begin
      w_state_nxt = IDLE;
      w_err       = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_tcnt <= '0;
    else if (r_state == IDLE || bus.rx_valid)
      r_tcnt <= '0;
    else
      r_tcnt <= r_tcnt + 20'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_left   <= 1'b0;
      r_right  <= 1'b0;
      r_fire   <= 1'b0;
      r_pause  <= 1'b0;
      r_paused <= 1'b0;
      r_fire_p <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_fire_p <= 1'b0;
      r_err    <= w_err;
      if (w_make) begin
        case (bus.rx_data)
          LEFT_CODE:  r_left  <= 1'b1;
          RIGHT_CODE: r_right <= 1'b1;
          FIRE_CODE: begin
            r_fire   <= 1'b1;
            r_fire_p <= !r_fire && !r_paused;
          end
          PAUSE_CODE: begin
            r_pause <= 1'b1;
            if (!r_pause) r_paused <= !r_paused;
          end
          default: ;
        endcase
      end else if (w_brk) begin
        case (bus.rx_data)
          LEFT_CODE:  r_left  <= 1'b0;
          RIGHT_CODE: r_right <= 1'b0;
          FIRE_CODE:  r_fire  <= 1'b0;
          PAUSE_CODE: r_pause <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign w_l = r_left & ~r_right & ~r_paused;
  assign w_r = r_right & ~r_left & ~r_paused;

  // A flip straight from one direction to the other restarts the period
  assign w_fresh = (w_l & r_dir_r) | (w_r & r_dir_l);
  assign w_cur   = w_fresh ? '0 : r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_mv_l  <= 1'b0;
      r_mv_r  <= 1'b0;
      r_dir_l <= 1'b0;
      r_dir_r <= 1'b0;
    end else begin
      r_dir_l <= w_l;
      r_dir_r <= w_r;
      if (!(w_l | w_r)) begin
        r_cnt  <= '0;
        r_mv_l <= 1'b0;
        r_mv_r <= 1'b0;
      end else begin
        r_mv_l <= w_l && (w_cur == '0);
        r_mv_r <= w_r && (w_cur == '0);
        if (w_cur == MOVE_DIV - 20'd1) r_cnt <= '0;
        else                           r_cnt <= w_cur + 20'd1;
      end
    end
  end

  assign bus.key_left   = r_left;
  assign bus.key_right  = r_right;
  assign bus.key_fire   = r_fire;
  assign bus.paused     = r_paused;
  assign bus.move_left  = r_mv_l;
  assign bus.move_right = r_mv_r;
  assign bus.fire_pulse = r_fire_p;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: cycle-level model
// compared every cycle plus literal timing pins.
module tb_ps2_key_ctrl;

  localparam int DIV = 4;
  localparam int TO  = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   t_last = 0;
  int   fp_cnt = 0;
  int   ml_q[$];
  int   mr_q[$];
  int   er_q[$];

  ps2_key_ctrl_if bus();

  ps2_key_ctrl #(
    .MOVE_DIV(20'd4),
    .TIMEOUT (20'd16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] dut_v;
  assign dut_v = {bus.key_left, bus.key_right,
                  bus.key_fire, bus.paused,
                  bus.move_left, bus.move_right,
                  bus.fire_pulse, bus.err};

  typedef struct packed {
    bit ext;
    bit brk;
    int last;
    bit kl, kr, kf, kp, pz;
    bit ml, mr, fp, er;
    bit inl, inr;
    int sl, sr;
  } m_t;

  m_t m = '0;

  // Next-cycle view from the current levels and this cycle's byte
  function automatic m_t step(m_t c, bit v, logic [7:0] d, int t);
    m_t n;
    bit mk, bk, l, r;
    n = c;
    mk = 0;
    bk = 0;
    n.fp = 0;
    n.er = 0;
    l = c.kl && !c.kr && !c.pz;
    r = c.kr && !c.kl && !c.pz;
    n.inl = l;
    n.inr = r;
    if (l && !c.inl) n.sl = t;
    if (r && !c.inr) n.sr = t;
    n.ml = l && ((t - n.sl) % DIV == 0);
    n.mr = r && ((t - n.sr) % DIV == 0);
    if (v) begin
      n.last = t;
      if (!c.ext && !c.brk) begin
        if (d == 8'hE0) n.ext = 1;
        else if (d == 8'hF0) n.brk = 1;
        else if (!(d inside {8'hE1, 8'hAA, 8'hFA,
                             8'hFE, 8'h00, 8'hFF})) mk = 1;
      end else if (c.brk) begin
        if (d == 8'hE0 || d == 8'hF0) n.er = 1;
        else bk = 1;
        n.ext = 0;
        n.brk = 0;
      end else begin
        if (d == 8'hF0) n.brk = 1;
        else begin
          if (d == 8'hE0) n.er = 1;
          else mk = 1;
          n.ext = 0;
        end
      end
    end else if ((c.ext || c.brk) && (t - c.last == TO - 1)) begin
      n.er = 1;
      n.ext = 0;
      n.brk = 0;
    end
    if (mk) begin
      if (d == 8'h6B) n.kl = 1;
      if (d == 8'h74) n.kr = 1;
      if (d == 8'h29) begin
        if (!c.kf && !c.pz) n.fp = 1;
        n.kf = 1;
      end
      if (d == 8'h4D) begin
        if (!c.kp) n.pz = !c.pz;
        n.kp = 1;
      end
    end
    if (bk) begin
      if (d == 8'h6B) n.kl = 0;
      if (d == 8'h74) n.kr = 0;
      if (d == 8'h29) n.kf = 0;
      if (d == 8'h4D) n.kp = 0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= '0;
    else      m <= step(m, bus.rx_valid, bus.rx_data, cyc);
  end

  logic [7:0] exp_v;
  assign exp_v = {m.kl, m.kr, m.kf, m.pz,
                  m.ml, m.mr, m.fp, m.er};

  always @(negedge clk) begin
    tests++;
    if (dut_v !== exp_v) begin
      fails++;
      $display("FAIL cycle_cmp @%0d: got %b expected %b",
               cyc, dut_v, exp_v);
    end
    if (bus.move_left)  ml_q.push_back(cyc);
    if (bus.move_right) mr_q.push_back(cyc);
    if (bus.err)        er_q.push_back(cyc);
    if (bus.fire_pulse) fp_cnt++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    t_last = cyc;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int f0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    idle(3);
    chk("reset_out", int'(dut_v), 0);
    rst = 1'b1;
    idle(2);

    send(8'hE0);
    send(8'h6B);
    n = t_last;
    ml_q.delete();
    chk("left_level", int'(bus.key_left), 1);
    idle(11);
    chk("ml_count", ml_q.size(), 3);
    if (ml_q.size() >= 3) begin
      chk("ml_first", ml_q[0] - n, 2);
      chk("ml_second", ml_q[1] - n, 6);
      chk("ml_third", ml_q[2] - n, 10);
    end
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    chk("left_brk", int'(bus.key_left), 0);
    idle(1);
    ml_q.delete();
    idle(10);
    chk("ml_stop", ml_q.size(), 0);

    send(8'h6B);
    send(8'h74);
    idle(1);
    ml_q.delete();
    mr_q.delete();
    idle(8);
    chk("both_ml", ml_q.size(), 0);
    chk("both_mr", mr_q.size(), 0);
    send(8'hF0);
    send(8'h6B);
    n = t_last;
    idle(10);
    chk("mr_count", mr_q.size(), 3);
    if (mr_q.size() >= 2) begin
      chk("mr_first", mr_q[0] - n, 2);
      chk("mr_second", mr_q[1] - n, 6);
    end
    send(8'hF0);
    send(8'h74);

    idle(2);
    fp_cnt = 0;
    send(8'h29);
    send(8'h29);
    send(8'h29);
    send(8'hF0);
    send(8'h29);
    send(8'h29);
    send(8'hF0);
    send(8'h29);
    chk("fire_count", fp_cnt, 2);

    send(8'h4D);
    chk("paused_on", int'(bus.paused), 1);
    ml_q.delete();
    send(8'h6B);
    idle(10);
    chk("paused_left", int'(bus.key_left), 1);
    chk("paused_ml", ml_q.size(), 0);
    send(8'h29);
    chk("paused_fire_lvl", int'(bus.key_fire), 1);
    send(8'hF0);
    send(8'h6B);
    send(8'hF0);
    send(8'h4D);
    send(8'h4D);
    chk("paused_off", int'(bus.paused), 0);
    chk("paused_fire_cnt", fp_cnt, 2);
    send(8'hF0);
    send(8'h4D);
    send(8'hF0);
    send(8'h29);

    er_q.delete();
    send(8'hF0);
    f0 = t_last;
    idle(20);
    chk("tout_count", er_q.size(), 1);
    if (er_q.size() >= 1)
      chk("tout_delay", er_q[0] - f0, 16);
    send(8'h6B);
    chk("tout_make", int'(bus.key_left), 1);
    send(8'hF0);
    send(8'h6B);

    er_q.delete();
    send(8'hE0);
    send(8'hE0);
    n = t_last;
    idle(1);
    chk("e0e0_err", er_q.size(), 1);
    if (er_q.size() >= 1) chk("e0e0_at", er_q[0] - n, 1);
    er_q.delete();
    send(8'hF0);
    send(8'hF0);
    n = t_last;
    idle(1);
    chk("f0f0_err", er_q.size(), 1);
    if (er_q.size() >= 1) chk("f0f0_at", er_q[0] - n, 1);

    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hE0;
    @(negedge clk);
    bus.rx_data  = 8'h6B;
    @(negedge clk);
    bus.rx_data  = 8'hE0;
    @(negedge clk);
    bus.rx_data  = 8'hF0;
    @(negedge clk);
    bus.rx_data  = 8'h6B;
    @(negedge clk);
    bus.rx_data  = 8'h29;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    chk("b2b_left", int'(bus.key_left), 0);
    chk("b2b_fire", int'(bus.key_fire), 1);
    send(8'hF0);
    send(8'h29);

    send(8'h6B);
    send(8'hE0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("rst_async", int'(dut_v), 0);
    @(posedge clk);
    #2 rst = 1'b1;
    send(8'hF0);
    send(8'h6B);
    chk("orphan_brk", int'(bus.key_left), 0);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
